// File: rtl/id_inst_buffer.sv
// Two-entry instruction buffer between fetch and decode.
// Each entry stores the immediate type, which is decoded from the opcode when the entry is pushed.
module id_inst_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [24:0] out_inst_hi,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_imm_type,
  output logic [31:0] out_pc
);

  localparam logic [1:0] FullCount = 2'(DEPTH);

  typedef enum logic [2:0] {
    NOTYPE = 3'd0,
    RTYPE  = 3'd1,
    ITYPE  = 3'd2,
    STYPE  = 3'd3,
    BTYPE  = 3'd4,
    UTYPE  = 3'd5,
    JTYPE  = 3'd6
  } imm_type_e;

  logic [1:0]  count_q, count_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [31:0] inst_q [2];
  logic [31:0] inst_d [2];
  logic [31:0] pc_q [2];
  logic [31:0] pc_d [2];
  imm_type_e   type_q [2];
  imm_type_e   type_d [2];
  imm_type_e   in_type;
  logic        push;
  logic        pop;

  always_comb begin
    case (in_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: in_type = ITYPE;
      7'b0100011:                         in_type = STYPE;
      7'b1100011:                         in_type = BTYPE;
      7'b0110111, 7'b0010111:             in_type = UTYPE;
      7'b1101111:                         in_type = JTYPE;
      7'b0110011:                         in_type = RTYPE;
      default:                            in_type = NOTYPE;
    endcase
  end

  // in_ready depends only on registered state, so it reports the pre-flush count during a flush cycle
  assign in_ready  = (count_q != FullCount);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    inst_d   = inst_q;
    pc_d     = pc_q;
    type_d   = type_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        inst_d[wr_ptr_q] = in_inst;
        pc_d[wr_ptr_q]   = in_pc;
        type_d[wr_ptr_q] = in_type;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage is not reset; the count alone decides whether an entry is visible
  always_ff @(posedge clk) begin
    inst_q <= inst_d;
    pc_q   <= pc_d;
    type_q <= type_d;
  end

  always_comb begin
    out_inst_hi  = 25'd0;
    out_opcode   = 7'd0;
    out_imm_type = 3'd0;
    out_pc       = 32'd0;
    if (out_valid) begin
      out_inst_hi  = inst_q[rd_ptr_q][31:7];
      out_opcode   = inst_q[rd_ptr_q][6:0];
      out_imm_type = type_q[rd_ptr_q];
      out_pc       = pc_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_id_inst_buffer.sv
// Directed testbench for id_inst_buffer.
// Inputs are driven and outputs are sampled 1ns after each rising edge.
module tb_id_inst_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_inst_hi;
  logic [6:0]  out_opcode;
  logic [2:0]  out_imm_type;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_inst_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst_hi(out_inst_hi), .out_opcode(out_opcode),
    .out_imm_type(out_imm_type), .out_pc(out_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = 32'h0; flush = 1'b0; out_ready = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({out_inst_hi, out_opcode, out_imm_type, out_pc} !== 67'd0) begin errors++;
      $display("[TB] FAIL reset_data got %h/%h/%h/%h exp 0", out_inst_hi, out_opcode, out_imm_type, out_pc); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_push();
    // addi x1,x0,10: bits [31:7] = 12'h00A,8'h00,5'd1 = 25'h0014001
    push_one(32'h00A00093, 32'h0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL addi_valid got %b exp 1", out_valid); end
    checks++; if (out_imm_type !== 3'd2) begin errors++; $display("[TB] FAIL addi_type got %0d exp 2", out_imm_type); end
    checks++; if (out_opcode !== 7'h13) begin errors++; $display("[TB] FAIL addi_opcode got %h exp 13", out_opcode); end
    checks++; if (out_inst_hi !== 25'h0014001) begin errors++; $display("[TB] FAIL addi_hi got %h exp 0014001", out_inst_hi); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL addi_pc got %h exp 0", out_pc); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL addi_pop_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_full();
    push_one(32'hFE000EE3, 32'h100);
    push_one(32'h0040006F, 32'h104);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready got %b exp 0", in_ready); end
    checks++; if (out_imm_type !== 3'd4) begin errors++; $display("[TB] FAIL full_head_type got %0d exp 4", out_imm_type); end
    in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 32'h108;
    tick(); tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL held_in_ready got %b exp 0", in_ready); end
    checks++; if (out_inst_hi !== 25'h1FC001D || out_opcode !== 7'h63 || out_pc !== 32'h100 || out_imm_type !== 3'd4) begin errors++;
      $display("[TB] FAIL held_head got %h/%h/%h/%0d exp 1fc001d/63/100/4", out_inst_hi, out_opcode, out_pc, out_imm_type); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_imm_type !== 3'd6 || out_opcode !== 7'h6F || out_inst_hi !== 25'h0008000 || out_pc !== 32'h104) begin errors++;
      $display("[TB] FAIL jal_head got %h/%h/%h/%0d exp 0008000/6f/104/6", out_inst_hi, out_opcode, out_pc, out_imm_type); end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_drain_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_push_pop();
    push_one(32'h00000033, 32'h200);
    in_valid = 1'b1; in_inst = 32'h00000037; in_pc = 32'h204; out_ready = 1'b1;
    checks++; if (out_imm_type !== 3'd1 || out_pc !== 32'h200) begin errors++;
      $display("[TB] FAIL pp_head_before got %0d/%h exp 1/200", out_imm_type, out_pc); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++;
      $display("[TB] FAIL pp_count_one got valid %b ready %b exp 1 1", out_valid, in_ready); end
    checks++; if (out_imm_type !== 3'd5 || out_pc !== 32'h204 || out_opcode !== 7'h37) begin errors++;
      $display("[TB] FAIL pp_head_after got %0d/%h/%h exp 5/204/37", out_imm_type, out_pc, out_opcode); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL pp_drain_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    push_one(32'h00000003, 32'h300);
    push_one(32'h00000023, 32'h304);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00000017; in_pc = 32'h308; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_pre_ready got %b exp 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("[TB] FAIL flush_state got valid %b ready %b exp 0 1", out_valid, in_ready); end
    checks++; if ({out_inst_hi, out_opcode, out_imm_type, out_pc} !== 67'd0) begin errors++;
      $display("[TB] FAIL flush_data got %h/%h/%h/%h exp 0", out_inst_hi, out_opcode, out_imm_type, out_pc); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_ghost_valid got %b exp 0", out_valid); end
    push_one(32'h00000067, 32'h400);
    checks++; if (out_imm_type !== 3'd2 || out_pc !== 32'h400 || out_opcode !== 7'h67) begin errors++;
      $display("[TB] FAIL flush_next_head got %0d/%h/%h exp 2/400/67", out_imm_type, out_pc, out_opcode); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    push_one(32'h00000013, 32'h500);
    push_one(32'h00000013, 32'h504);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ar_full_ready got %b exp 0", in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("[TB] FAIL ar_state got valid %b ready %b exp 0 1", out_valid, in_ready); end
    checks++; if (out_pc !== 32'h0 || out_opcode !== 7'h0) begin errors++;
      $display("[TB] FAIL ar_data got %h/%h exp 0/0", out_pc, out_opcode); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_after_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_opcode_sweep();
    logic [6:0] ops [10];
    logic [2:0] exp_type [10];
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
    exp_type = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd1, 3'd0};
    for (int i = 0; i < 10; i++) begin
      push_one({25'h1ABCDE5, ops[i]}, 32'h600 + 32'(i * 4));
      checks++; if (out_imm_type !== exp_type[i] || out_opcode !== ops[i] || out_inst_hi !== 25'h1ABCDE5) begin errors++;
        $display("[TB] FAIL sweep_%h got %0d/%h/%h exp %0d/%h/1abcde5", ops[i], out_imm_type, out_opcode, out_inst_hi, exp_type[i], ops[i]); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_full();
    test_push_pop();
    test_flush();
    test_async_reset();
    test_opcode_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
